// File: rtl/memoria_datos_ext.sv
// MEM-stage data memory: byte/half/word loads and stores with sign/zero
// extension, alignment-fault detection and a valid/ready debug dump engine.
module memoria_datos_ext #(
  parameter int NBITS     = 32,
  parameter int CELDAS    = 64,
  parameter int NBITS_IDX = $clog2(CELDAS)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NBITS-1:0]     i_ALUDireccion,
  input  logic [NBITS-1:0]     i_DatoRegistro,
  input  logic                 i_MemWrite,
  input  logic                 i_MemRead,
  input  logic [1:0]           i_Tamano,
  input  logic                 i_SinSigno,
  output logic [NBITS-1:0]     o_DatoLeido,
  output logic                 o_ErrorAlineacion,
  input  logic                 i_DebugInicio,
  input  logic                 i_DebugListo,
  output logic                 o_DebugValido,
  output logic [NBITS-1:0]     o_DebugDato,
  output logic [NBITS_IDX-1:0] o_DebugDireccion,
  output logic                 o_DebugOcupado,
  output logic                 o_DebugFin
);

  typedef enum logic {IDLE, ENVIO} estado_t;

  localparam logic [NBITS_IDX-1:0] ULTIMO = NBITS_IDX'(CELDAS - 1);

  logic [NBITS-1:0]     r_mem [CELDAS];
  estado_t              r_estado;
  estado_t              w_siguiente;
  logic                 r_valido;
  logic                 r_fin;
  logic [NBITS-1:0]     r_dato;
  logic [NBITS_IDX-1:0] r_dir;

  logic [NBITS_IDX-1:0] w_idx;
  logic [NBITS-1:0]     w_palabra;
  logic [7:0]           w_byte;
  logic [15:0]          w_media;
  logic                 w_desalineado;
  logic                 w_unused_dir;

  // Upper address bits are ignored so accesses wrap modulo CELDAS*4.
  assign w_idx        = i_ALUDireccion[NBITS_IDX+1:2];
  assign w_unused_dir = &{1'b0, i_ALUDireccion[NBITS-1:NBITS_IDX+2]};
  assign w_palabra    = r_mem[w_idx];
  assign w_byte       = w_palabra[{i_ALUDireccion[1:0], 3'b000} +: 8];
  assign w_media      = w_palabra[{i_ALUDireccion[1], 4'b0000} +: 16];

  // Alignment check by access size.
  always_comb begin
    unique case (i_Tamano)
      2'b00:   w_desalineado = 1'b0;
      2'b01:   w_desalineado = i_ALUDireccion[0];
      default: w_desalineado = (i_ALUDireccion[1:0] != 2'b00);
    endcase
  end

  assign o_ErrorAlineacion = (i_MemRead | i_MemWrite) & w_desalineado;

  // Combinational load path with lane select and extension.
  always_comb begin
    o_DatoLeido = '0;
    if (i_MemRead && !w_desalineado) begin
      unique case (i_Tamano)
        2'b00: o_DatoLeido = i_SinSigno ? {{(NBITS-8){1'b0}}, w_byte}
                                        : {{(NBITS-8){w_byte[7]}}, w_byte};
        2'b01: o_DatoLeido = i_SinSigno ? {{(NBITS-16){1'b0}}, w_media}
                                        : {{(NBITS-16){w_media[15]}}, w_media};
        default: o_DatoLeido = w_palabra;
      endcase
    end
  end

  // Memory array: reset to identity contents, lane-masked stores.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < CELDAS; i++) r_mem[i] <= NBITS'(i);
    end else if (i_MemWrite && !w_desalineado) begin
      unique case (i_Tamano)
        2'b00:   r_mem[w_idx][{i_ALUDireccion[1:0], 3'b000} +: 8] <= i_DatoRegistro[7:0];
        2'b01:   r_mem[w_idx][{i_ALUDireccion[1], 4'b0000} +: 16] <= i_DatoRegistro[15:0];
        default: r_mem[w_idx] <= i_DatoRegistro;
      endcase
    end
  end

  // Dump FSM state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_estado <= IDLE;
    else         r_estado <= w_siguiente;
  end

  // Dump FSM next state.
  always_comb begin
    w_siguiente = r_estado;
    unique case (r_estado)
      IDLE:  if (i_DebugInicio) w_siguiente = ENVIO;
      ENVIO: if (i_DebugListo && r_dir == ULTIMO) w_siguiente = IDLE;
      default: w_siguiente = IDLE;
    endcase
  end

  // Dump datapath: next word is fetched on the edge the current one is accepted.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valido <= 1'b0;
      r_fin    <= 1'b0;
      r_dato   <= '0;
      r_dir    <= '0;
    end else begin
      r_fin <= 1'b0;
      unique case (r_estado)
        IDLE: begin
          if (i_DebugInicio) begin
            r_dato   <= r_mem[0];
            r_dir    <= '0;
            r_valido <= 1'b1;
          end
        end
        ENVIO: begin
          if (i_DebugListo) begin
            if (r_dir == ULTIMO) begin
              r_valido <= 1'b0;
              r_fin    <= 1'b1;
            end else begin
              r_dir  <= r_dir + 1'b1;
              r_dato <= r_mem[r_dir + 1'b1];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_DebugValido    = r_valido;
  assign o_DebugFin       = r_fin;
  assign o_DebugDato      = r_dato;
  assign o_DebugDireccion = r_dir;
  assign o_DebugOcupado   = (r_estado == ENVIO);

endmodule

// File: tb/tb_memoria_datos_ext.sv
// Self-checking bench for memoria_datos_ext (CELDAS=64).
module tb_memoria_datos_ext;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, dreg;
  logic        mw, mr, uns, inicio, listo;
  logic [1:0]  tam;
  logic [31:0] dleido, ddato;
  logic        err, valido, ocup, fin;
  logic [5:0]  ddir;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q_load [$];
  logic [37:0] q_dump [$];

  always #5 clk = ~clk;

  memoria_datos_ext #(.NBITS(32), .CELDAS(64)) dut (
    .i_clk(clk), .i_reset(rst), .i_ALUDireccion(addr), .i_DatoRegistro(dreg),
    .i_MemWrite(mw), .i_MemRead(mr), .i_Tamano(tam), .i_SinSigno(uns),
    .o_DatoLeido(dleido), .o_ErrorAlineacion(err),
    .i_DebugInicio(inicio), .i_DebugListo(listo), .o_DebugValido(valido),
    .o_DebugDato(ddato), .o_DebugDireccion(ddir), .o_DebugOcupado(ocup),
    .o_DebugFin(fin)
  );

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
    @(negedge clk);
    addr = a; dreg = d; tam = t; mw = 1'b1; mr = 1'b0;
    @(posedge clk);
    #1 mw = 1'b0;
  endtask

  task automatic chk_load(input string nm, input logic [31:0] a, input logic [1:0] t,
                          input logic u, input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] e;
    @(negedge clk);
    addr = a; tam = t; uns = u; mr = 1'b1; mw = 1'b0;
    q_load.push_back(exp_d);
    #1;
    e = q_load.pop_front();
    n_checks++;
    if (dleido !== e) begin
      n_fail++; $display("FAIL %s data: got %h expected %h", nm, dleido, e);
    end
    n_checks++;
    if (err !== exp_e) begin
      n_fail++; $display("FAIL %s fault: got %b expected %b", nm, err, exp_e);
    end
    mr = 1'b0;
  endtask

  // mode 0: ready held high; 1: ready toggles 1,0,1,0; 2: ready high plus a store to word 40 while word 10 is presented
  task automatic run_dump(input int mode, output int cycles, output int fins);
    logic [31:0] h_dato, v;
    logic [5:0]  h_dir;
    logic [37:0] e;
    logic        prev_listo, stored;
    q_dump.delete();
    for (int i = 0; i < 64; i++) begin
      v = (mode == 2 && i == 40) ? 32'hCAFEF00D : 32'(i);
      q_dump.push_back({6'(i), v});
    end
    @(negedge clk);
    listo = 1'b1; inicio = 1'b1;
    prev_listo = 1'b1; stored = 1'b0; h_dato = '0; h_dir = '0;
    cycles = 0; fins = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      inicio = 1'b0;
      mw = 1'b0;
      if (fin) begin
        fins++;
        break;
      end
      if (valido && !prev_listo) begin
        n_checks++;
        if (ddato !== h_dato || ddir !== h_dir) begin
          n_fail++;
          $display("FAIL dump_hold: got %0d:%h expected %0d:%h", ddir, ddato, h_dir, h_dato);
        end
      end
      if (valido && listo) begin
        e = (q_dump.size() > 0) ? q_dump.pop_front() : 38'h3F_FFFFFFFF;
        n_checks++;
        if ({ddir, ddato} !== e) begin
          n_fail++;
          $display("FAIL dump_word: got %0d:%h expected %0d:%h", ddir, ddato, e[37:32], e[31:0]);
        end
      end
      if (mode == 2 && valido && ddir == 6'd10 && !stored) begin
        addr = 32'hA0; dreg = 32'hCAFEF00D; tam = 2'b10; mw = 1'b1; stored = 1'b1;
      end
      if (mode == 1) listo = ~listo;
      h_dato = ddato; h_dir = ddir; prev_listo = listo;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; #2; rst = 1'b0;
    n_checks++;
    if ({valido, fin, ocup, ddir, ddato} !== '0) begin
      n_fail++; $display("FAIL reset_state: got v%b f%b o%b %0d %h expected all zero", valido, fin, ocup, ddir, ddato);
    end
    do_store(32'h14, 32'h0000FFFF, 2'b10);
    @(negedge clk);
    inicio = 1'b1; listo = 1'b0;
    @(negedge clk);
    inicio = 1'b0;
    n_checks++;
    if (valido !== 1'b1 || ocup !== 1'b1) begin
      n_fail++; $display("FAIL dump_start: got v%b o%b expected v1 o1", valido, ocup);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (valido !== 1'b0 || ocup !== 1'b0) begin
      n_fail++; $display("FAIL reset_middump: got v%b o%b expected v0 o0", valido, ocup);
    end
    #1 rst = 1'b0;
    chk_load("reset_word5", 32'h14, 2'b10, 1'b0, 32'h00000005, 1'b0);
  endtask

  task automatic test_loads();
    @(negedge clk);
    addr = 32'h10; dreg = 32'h8899AABC; tam = 2'b10; mw = 1'b1; mr = 1'b1;
    #1;
    n_checks++;
    if (dleido !== 32'h00000004) begin
      n_fail++; $display("FAIL load_prewrite: got %h expected %h", dleido, 32'h4);
    end
    @(posedge clk);
    #1 mw = 1'b0; mr = 1'b0;
    chk_load("lb_13",  32'h13, 2'b00, 1'b0, 32'hFFFFFF88, 1'b0);
    chk_load("lbu_13", 32'h13, 2'b00, 1'b1, 32'h00000088, 1'b0);
    chk_load("lh_10",  32'h10, 2'b01, 1'b0, 32'hFFFFAABC, 1'b0);
    chk_load("lhu_12", 32'h12, 2'b01, 1'b1, 32'h00008899, 1'b0);
    chk_load("lw_uns", 32'h10, 2'b11, 1'b1, 32'h8899AABC, 1'b0);
  endtask

  task automatic test_narrow_stores();
    do_store(32'h11, 32'h12345677, 2'b00);
    do_store(32'h12, 32'h0000BEEF, 2'b01);
    chk_load("narrow_lw", 32'h10, 2'b10, 1'b0, 32'hBEEF77BC, 1'b0);
  endtask

  task automatic test_alignment();
    @(negedge clk);
    addr = 32'h22; dreg = 32'h55555555; tam = 2'b10; mw = 1'b1; mr = 1'b0;
    #1;
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL sw_fault: got %b expected 1", err);
    end
    @(posedge clk);
    #1 mw = 1'b0;
    chk_load("word8_kept", 32'h20, 2'b10, 1'b0, 32'h00000008, 1'b0);
    chk_load("lh_21",      32'h21, 2'b01, 1'b0, 32'h00000000, 1'b1);
    chk_load("lb_21",      32'h21, 2'b00, 1'b0, 32'h00000000, 1'b0);
    chk_load("noread_lw",  32'h23, 2'b10, 1'b0, 32'h00000000, 1'b1);
  endtask

  task automatic test_wrap();
    do_store(32'h100, 32'hDEADBEEF, 2'b10);
    chk_load("wrap_lw", 32'h000, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
  endtask

  task automatic test_dump_full();
    int c, f;
    apply_reset();
    run_dump(0, c, f);
    n_checks++;
    if (c !== 65 || f !== 1) begin
      n_fail++; $display("FAIL dump_full_len: got %0d cycles %0d fin expected 65 cycles 1 fin", c, f);
    end
    n_checks++;
    if (q_dump.size() !== 0) begin
      n_fail++; $display("FAIL dump_full_count: got %0d left expected 0", q_dump.size());
    end
    inicio = 1'b1;
    @(posedge clk);
    #1 inicio = 1'b0;
    n_checks++;
    if (fin !== 1'b0 || valido !== 1'b1 || ocup !== 1'b1 || ddir !== 6'd0) begin
      n_fail++; $display("FAIL back_to_back: got f%b v%b o%b %0d expected f0 v1 o1 0", fin, valido, ocup, ddir);
    end
    apply_reset();
  endtask

  task automatic test_dump_toggle();
    int c, f;
    run_dump(1, c, f);
    n_checks++;
    if (f !== 1 || q_dump.size() !== 0) begin
      n_fail++; $display("FAIL dump_toggle_end: got %0d fin %0d left expected 1 fin 0 left", f, q_dump.size());
    end
    apply_reset();
  endtask

  task automatic test_dump_store();
    int c, f;
    run_dump(2, c, f);
    n_checks++;
    if (f !== 1 || q_dump.size() !== 0) begin
      n_fail++; $display("FAIL dump_store_end: got %0d fin %0d left expected 1 fin 0 left", f, q_dump.size());
    end
    chk_load("dump_store_lw", 32'hA0, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0);
  endtask

  initial begin
    rst = 1'b0; addr = '0; dreg = '0; mw = 1'b0; mr = 1'b0; tam = 2'b00;
    uns = 1'b0; inicio = 1'b0; listo = 1'b0;
    test_reset();
    test_loads();
    test_narrow_stores();
    test_alignment();
    test_wrap();
    test_dump_full();
    test_dump_toggle();
    test_dump_store();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
